connect4_move_ctrl: RTL and testbench
=====================================

// Module: connect4_move_ctrl
// PURPOSE
//  Consumer of the debounced one-cycle button pulses (left/right/put) from the input
//  conditioning stage. Tracks cursor column, whose turn it is, per-column fill heights
//  and board occupancy. Turns a put into a validated piece drop reported to the
//  game/display logic. Provides a registered cell read port for the display scanner.
// PARAMETERS
//  COLS   7  board columns (2..8)
//  ROWS   6  board rows (2..8)
//  COL_W  3  cursor/column index width, >= clog2(COLS)
//  ROW_W  3  row index width, >= clog2(ROWS)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-low
//  left_pulse   in   1      one-cycle move-cursor-left request
//  right_pulse  in   1      one-cycle move-cursor-right request
//  put_pulse    in   1      one-cycle drop-piece request
//  new_game     in   1      synchronous clear of board/cursor/turn (same effect as reset)
//  rd_col       in   COL_W  display read column
//  rd_row       in   ROW_W  display read row (0 = bottom)
//  rd_cell      out  2      cell at (rd_col,rd_row), 1-cycle latency: 00 empty, 01 P1, 10 P2
//  cursor_col   out  COL_W  current cursor column
//  player       out  1      player to move: 0 = P1, 1 = P2
//  drop_valid   out  1      one-cycle strobe: piece placed
//  drop_col     out  COL_W  column of placed piece (valid with drop_valid)
//  drop_row     out  ROW_W  row of placed piece (valid with drop_valid)
//  drop_player  out  1      owner of placed piece (valid with drop_valid)
//  col_full_err out  1      one-cycle strobe: put rejected, column full
//  board_full   out  1      all ROWS*COLS cells occupied; level signal
// BEHAVIOUR
//  - Reset (rst=0 at clk edge) or new_game=1: all cells empty, all heights 0,
//    cursor_col=0, player=0, move count 0, state PLAY. Outputs drop_valid,
//    col_full_err, board_full, rd_cell, drop_col, drop_row, drop_player = 0.
//    rst has priority over new_game; both abort any operation in progress.
//  - FSM: PLAY -> DROP (accepted put) -> PLAY, or -> OVER after last cell filled.
//    OVER held until rst/new_game.
//  - Input priority in PLAY, same cycle: put > left/right. left and right together are
//    both ignored. All pulses are ignored in DROP and OVER (not queued).
//  - left: cursor_col-1, wraps 0 -> COLS-1. right: cursor_col+1, wraps COLS-1 -> 0.
//    Cursor updates on the edge after the pulse.
//  - put at cycle N with c=cursor_col, h=height[c]:
//    h<ROWS: cycle N+1 state DROP, drop_valid=1, drop_col=c, drop_row=h, drop_player=player,
//            cell(c,h) written. At edge ending N+1: height[c]=h+1, count+1, player toggles,
//            state PLAY, or OVER with board_full=1 if count reaches ROWS*COLS.
//    h==ROWS: col_full_err=1 in cycle N+1 only. State, player and cursor unchanged.
//  - drop_valid and col_full_err are never asserted together. Each lasts exactly 1 cycle.
//  - Heights saturate at ROWS. Move count width = clog2(ROWS*COLS+1), no wrap.
//  - rd_cell registered: reflects cell state at the edge rd_col/rd_row were sampled.
//    Out-of-range rd_col/rd_row returns 00. A write and a read to the same cell in the
//    same cycle return the old value.
//  - Cursor stays on its column after a drop. Cursor movement is allowed on full columns.
// TESTING
//  1 reset; left_pulse x1 -> cursor_col=6; right_pulse x2 -> cursor_col=1
//  2 put at col 3 -> next cycle drop_valid=1, col 3, row 0, player 0; then player=1;
//    rd(3,0) -> 01 one cycle later
//  3 6 puts on col 0 (wait out DROP each) -> rows 0..5, alternating players;
//    7th put -> col_full_err=1 only, player unchanged
//  4 left+put in same cycle -> drop at old cursor, cursor unchanged;
//    left+right same cycle -> no change; pulse during DROP -> ignored
//  5 fill all 42 cells -> board_full=1, state OVER; further puts produce no strobes;
//    new_game -> board_full=0, rd_cell=00 everywhere, player=0
//  6 rst asserted in DROP cycle -> next cycle everything at reset values, no drop recorded

Source files
------------

// File: rtl/connect4_move_ctrl.sv
// Connect-4 move controller: cursor/turn tracking, validated piece drops,
// per-column fill heights and a registered board read port for the display.
module connect4_move_ctrl #(
  parameter int COLS  = 7,
  parameter int ROWS  = 6,
  parameter int COL_W = 3,
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left_pulse,
  input  logic             right_pulse,
  input  logic             put_pulse,
  input  logic             new_game,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [1:0]       rd_cell,
  output logic [COL_W-1:0] cursor_col,
  output logic             player,
  output logic             drop_valid,
  output logic [COL_W-1:0] drop_col,
  output logic [ROW_W-1:0] drop_row,
  output logic             drop_player,
  output logic             col_full_err,
  output logic             board_full
);

  localparam int TOTAL = ROWS * COLS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int HT_W  = $clog2(ROWS + 1);

  typedef enum logic [1:0] {S_PLAY, S_DROP, S_OVER} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_board [COLS][ROWS];
  logic [HT_W-1:0]  r_height [COLS];
  logic [CNT_W-1:0] r_count;
  logic [COL_W-1:0] r_cursor;
  logic             r_player;
  logic             r_drop_valid;
  logic [COL_W-1:0] r_drop_col;
  logic [ROW_W-1:0] r_drop_row;
  logic             r_drop_player;
  logic             r_col_full_err;
  logic             r_board_full;
  logic [1:0]       r_rd_cell;

  logic w_accept;
  logic w_reject;
  logic w_go_left;
  logic w_go_right;
  logic w_last;
  logic w_rd_in_range;

  always_ff @(posedge clk) begin
    if (!rst || new_game) r_state <= S_PLAY;
    else                  r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_go_left    = 1'b0;
    w_go_right   = 1'b0;
    w_last       = (r_count == CNT_W'(TOTAL - 1));
    unique case (r_state)
      S_PLAY: begin
        // put wins over cursor moves; simultaneous left+right cancel out
        if (put_pulse) begin
          if (r_height[r_cursor] < HT_W'(ROWS)) begin
            w_accept     = 1'b1;
            w_next_state = S_DROP;
          end else begin
            w_reject = 1'b1;
          end
        end else if (left_pulse && !right_pulse) begin
          w_go_left = 1'b1;
        end else if (right_pulse && !left_pulse) begin
          w_go_right = 1'b1;
        end
      end
      S_DROP:  w_next_state = w_last ? S_OVER : S_PLAY;
      S_OVER:  w_next_state = S_OVER;
      default: w_next_state = S_PLAY;
    endcase
  end

  assign w_rd_in_range = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);

  always_ff @(posedge clk) begin
    if (!rst || new_game) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        r_height[c] <= '0;
        for (int unsigned r = 0; r < ROWS; r++) r_board[c][r] <= '0;
      end
      r_count        <= '0;
      r_cursor       <= '0;
      r_player       <= 1'b0;
      r_drop_valid   <= 1'b0;
      r_drop_col     <= '0;
      r_drop_row     <= '0;
      r_drop_player  <= 1'b0;
      r_col_full_err <= 1'b0;
      r_board_full   <= 1'b0;
      r_rd_cell      <= '0;
    end else begin
      r_drop_valid   <= w_accept;
      r_col_full_err <= w_reject;
      if (w_accept) begin
        r_drop_col    <= r_cursor;
        r_drop_row    <= ROW_W'(r_height[r_cursor]);
        r_drop_player <= r_player;
      end
      if (w_go_left)
        r_cursor <= (r_cursor == '0) ? COL_W'(COLS - 1) : r_cursor - COL_W'(1);
      if (w_go_right)
        r_cursor <= (r_cursor == COL_W'(COLS - 1)) ? '0 : r_cursor + COL_W'(1);
      // The drop is committed at the end of the DROP cycle, so a reset
      // landing in that cycle leaves no trace of the piece.
      if (r_state == S_DROP) begin
        r_board[r_drop_col][r_drop_row] <= r_drop_player ? 2'b10 : 2'b01;
        r_height[r_drop_col]            <= r_height[r_drop_col] + HT_W'(1);
        r_count                         <= r_count + CNT_W'(1);
        r_player                        <= ~r_player;
        r_board_full                    <= w_last;
      end
      r_rd_cell <= w_rd_in_range ? r_board[rd_col][rd_row] : 2'b00;
    end
  end

  assign rd_cell      = r_rd_cell;
  assign cursor_col   = r_cursor;
  assign player       = r_player;
  assign drop_valid   = r_drop_valid;
  assign drop_col     = r_drop_col;
  assign drop_row     = r_drop_row;
  assign drop_player  = r_drop_player;
  assign col_full_err = r_col_full_err;
  assign board_full   = r_board_full;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// Bench for connect4_move_ctrl: vector table for cursor/turn behaviour plus
// hand sequences; drop/error strobes are matched against a queue of expected events.
module tb_connect4_move_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       left_pulse, right_pulse, put_pulse, new_game;
  logic [2:0] rd_col, rd_row;
  logic [1:0] rd_cell;
  logic [2:0] cursor_col;
  logic       player;
  logic       drop_valid;
  logic [2:0] drop_col, drop_row;
  logic       drop_player;
  logic       col_full_err;
  logic       board_full;

  connect4_move_ctrl #(.COLS(7), .ROWS(6), .COL_W(3), .ROW_W(3)) dut (
    .clk(clk), .rst(rst),
    .left_pulse(left_pulse), .right_pulse(right_pulse), .put_pulse(put_pulse),
    .new_game(new_game), .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell),
    .cursor_col(cursor_col), .player(player),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_row(drop_row),
    .drop_player(drop_player), .col_full_err(col_full_err), .board_full(board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int col;
    int row;
    int pl;
  } ev_t;

  typedef struct {
    logic l;
    logic r;
    logic p;
    logic push;
    int   ecol;
    int   erow;
    int   epl;
    int   cur;
    int   pl;
  } vec_t;

  ev_t  q[$];
  vec_t tab[13];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic expect_drop(input int c, input int r, input int pl);
    ev_t e;
    e.err = 0; e.col = c; e.row = r; e.pl = pl;
    q.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.err = 1; e.col = 0; e.row = 0; e.pl = 0;
    q.push_back(e);
  endtask

  task automatic cyc(input logic l, input logic r, input logic p);
    left_pulse = l; right_pulse = r; put_pulse = p;
    @(posedge clk);
    #1;
    left_pulse = 1'b0; right_pulse = 1'b0; put_pulse = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int c, input int r, input int exp);
    rd_col = 3'(c); rd_row = 3'(r);
    cyc(1'b0, 1'b0, 1'b0);
    chk(nm, rd_cell, exp);
  endtask

  // Strobe scoreboard: every strobe must match the oldest expected event.
  always begin
    @(posedge clk);
    #1;
    if (drop_valid || col_full_err) begin
      ev_t e;
      chk("strobe_exclusive", int'(drop_valid && col_full_err), 0);
      chk("sb_pending", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strobe_is_err", col_full_err, e.err);
        if (e.err == 0) begin
          chk("drop_col", drop_col, e.col);
          chk("drop_row", drop_row, e.row);
          chk("drop_player", drop_player, e.pl);
        end
      end
    end
  end

  initial begin
    int pm;
    rst = 1'b0; new_game = 1'b0;
    left_pulse = 1'b0; right_pulse = 1'b0; put_pulse = 1'b0;
    rd_col = '0; rd_row = '0;

    //              l  r  p  push col row pl  cur pl
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 6, 0};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 2, 0};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3, 0};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 0, 3, 0};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3, 1};
    tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3, 1, 1, 3, 1};
    tab[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3, 0};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3, 0};
    tab[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 0, 3, 0};
    tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3, 1};
    tab[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3, 1};

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rst_cursor", cursor_col, 0);
    chk("rst_player", player, 0);
    chk("rst_drop_valid", drop_valid, 0);
    chk("rst_col_full_err", col_full_err, 0);
    chk("rst_board_full", board_full, 0);
    chk("rst_rd_cell", rd_cell, 0);
    chk("rst_drop_col", drop_col, 0);

    for (int i = 0; i < 13; i++) begin
      if (tab[i].push) expect_drop(tab[i].ecol, tab[i].erow, tab[i].epl);
      cyc(tab[i].l, tab[i].r, tab[i].p);
      chk($sformatf("vec%0d_cursor", i), cursor_col, tab[i].cur);
      chk($sformatf("vec%0d_player", i), player, tab[i].pl);
    end

    rd_chk("rd_3_0", 3, 0, 1);
    rd_chk("rd_3_1", 3, 1, 2);
    rd_chk("rd_3_2", 3, 2, 1);
    rd_chk("rd_col_oob", 7, 0, 0);
    rd_chk("rd_row_oob", 0, 6, 0);

    // read of (3,3) sampled in the same cycle the piece is written sees the old value
    rd_col = 3'd3; rd_row = 3'd3;
    expect_drop(3, 3, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rd_before_write", rd_cell, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rd_same_cycle_old", rd_cell, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rd_after_write", rd_cell, 2);

    // column 0 filled to the top, then one more put
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("col0_cursor", cursor_col, 0);
    pm = 0;
    for (int r = 0; r < 6; r++) begin
      expect_drop(0, r, pm);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      pm ^= 1;
    end
    chk("col0_player", player, pm);
    expect_err();
    cyc(1'b0, 1'b0, 1'b1);
    chk("full_err_player", player, pm);
    chk("full_err_cursor", cursor_col, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("full_err_one_cycle", col_full_err, 0);
    chk("full_err_player_after", player, pm);
    cyc(1'b0, 1'b1, 1'b0);
    chk("move_after_err", cursor_col, 1);

    // fresh game, fill the whole board
    new_game = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    new_game = 1'b0;
    chk("ng_cursor", cursor_col, 0);
    chk("ng_player", player, 0);
    pm = 0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        expect_drop(c, r, pm);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        pm ^= 1;
        if (c == 6 && r == 4) chk("not_full_at_41", board_full, 0);
      end
      if (c < 6) cyc(1'b0, 1'b1, 1'b0);
    end
    chk("board_full", board_full, 1);
    chk("full_player", player, pm);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("over_cursor_held", cursor_col, 6);
    chk("over_board_full_held", board_full, 1);
    rd_chk("rd_full_0_0", 0, 0, 1);
    rd_chk("rd_full_6_5", 6, 5, 2);

    new_game = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    new_game = 1'b0;
    chk("ng2_board_full", board_full, 0);
    chk("ng2_player", player, 0);
    chk("ng2_cursor", cursor_col, 0);
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        rd_chk($sformatf("ng2_rd_%0d_%0d", c, r), c, r, 0);

    // reset during the DROP cycle discards the piece
    expect_drop(0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rstdrop_drop_valid", drop_valid, 0);
    chk("rstdrop_player", player, 0);
    chk("rstdrop_board_full", board_full, 0);
    rd_chk("rstdrop_rd_0_0", 0, 0, 0);
    expect_drop(0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rstdrop_player_after", player, 1);
    cyc(1'b0, 1'b0, 1'b0);

    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
